mem_access_seq: RTL

- Load/store sequencer that sits directly upstream of the data memory.
- Accepts one memory request at a time from the execute stage (valid/ready) and drives the memory's address, write-data, write-enable and mem-to-reg inputs.
- Splits 2-byte (wide) accesses into two consecutive byte accesses.
- Returns assembled load data, or store completion, to writeback as a one-cycle response pulse.

---
 rtl/mem_access_seq.sv | 71 +++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: byte-serial load/store sequencer between the execute stage and the data memory.
// Wide accesses become two consecutive byte accesses; results return as a one-cycle response pulse.
module mem_access_seq #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_store,
  input  logic           req_wide,
  input  logic [A-1:0]   req_addr,
  input  logic [2*W-1:0] req_wdata,
  output logic [A-1:0]   dm_addr,
  output logic [W-1:0]   dm_wdata,
  output logic           dm_we,
  output logic           dm_mem_to_reg,
  input  logic [W-1:0]   dm_rdata,
  output logic           rsp_valid,
  output logic           rsp_is_load,
  output logic [2*W-1:0] rsp_data
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t         r_state, w_next;
  logic           r_store, r_wide;
  logic [A-1:0]   r_addr;
  logic [2*W-1:0] r_wdata;
  logic [W-1:0]   r_lo, r_hi;
  logic           w_acc0, w_acc1, w_resp;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_store <= 1'b0;
      r_wide  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_store <= req_store;
        r_wide  <= req_wide;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_lo    <= '0;
        r_hi    <= '0;
      end
      if (r_state == ACC0 && !r_store) r_lo <= dm_rdata;
      if (r_state == ACC1 && !r_store) r_hi <= dm_rdata;
    end
  end
  // every output is gated by reset so nothing leaks out while a stale state is still registered
  always_comb begin
    w_next = r_state == IDLE ? (req_valid ? ACC0 : IDLE) :
             r_state == ACC0 ? (r_wide ? ACC1 : RESP) :
             r_state == ACC1 ? RESP : IDLE;
    w_acc0        = r_state == ACC0 && !reset;
    w_acc1        = r_state == ACC1 && !reset;
    w_resp        = r_state == RESP && !reset;
    req_ready     = r_state == IDLE && !reset;
    dm_addr       = w_acc0 ? r_addr : w_acc1 ? r_addr + A'(1) : '0;
    dm_wdata      = w_acc0 ? r_wdata[W-1:0] : w_acc1 ? r_wdata[2*W-1:W] : '0;
    dm_we         = (w_acc0 || w_acc1) && r_store;
    dm_mem_to_reg = (w_acc0 || w_acc1) && !r_store;
    rsp_valid     = w_resp;
    rsp_is_load   = w_resp && !r_store;
    rsp_data      = (w_resp && !r_store) ? (r_wide ? {r_hi, r_lo} : {{W{1'b0}}, r_lo}) : '0;
  end
endmodule
